// File: rtl/status_display_if.sv
// status_display_if: event/clear/select inputs and hex/LED outputs of status_display.
interface status_display_if #(parameter int NUM_CH = 4);
    logic [NUM_CH-1:0] ev;
    logic              clr;
    logic [2:0]        sel;
    logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]        ledr;
    modport master (output ev, clr, sel, input hex0, hex1, hex2, hex3, hex4, hex5, ledr);
    modport slave  (input ev, clr, sel, output hex0, hex1, hex2, hex3, hex4, hex5, ledr);
endinterface

// File: rtl/status_display.sv
// status_display: saturating event counters shown on six hex digits with activity/saturation/heartbeat LEDs.
// Define STATUS_ACT_STRETCH_EN to stretch each activity LED for STRETCH_CYC cycles per event.
module status_display #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int REFRESH_CYC = 5000000,
    parameter int STRETCH_CYC = 2500000
) (
    input logic clk,
    input logic reset,
    status_display_if.slave bus
);
    localparam int RW = $clog2(REFRESH_CYC);
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] sat, act;
    logic [RW-1:0]     rc;
    logic [2:0]        sel_q;
    logic [23:0]       snap, cur;
    logic [6:0]        hex [6];
    logic              sat_sel, sat_led, hb, tick, sel_chg, selq_ok;

    assign tick    = rc == RW'(REFRESH_CYC - 1);
    assign sel_chg = bus.sel != sel_q;
    assign selq_ok = 32'(sel_q) < NUM_CH;

    // Out-of-range selections read as zero / not saturated
    always_comb begin
        cur     = '0;
        sat_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.sel == 3'(i)) begin
                cur     = 24'(cnt[i]);
                sat_sel = sat[i];
            end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            sat <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (bus.clr) begin
                    cnt[i] <= '0;
                    sat[i] <= 1'b0;
                end else if (bus.ev[i]) begin
                    if (&cnt[i]) sat[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + 1'b1;
                end
        end

    // A selection change reloads the snapshot at once and restarts the refresh period
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rc      <= '0;
            sel_q   <= '0;
            snap    <= '0;
            hb      <= 1'b0;
            sat_led <= 1'b0;
            for (int k = 0; k < 6; k++) hex[k] <= 7'b1000000;
        end else begin
            sel_q   <= bus.sel;
            rc      <= (tick || sel_chg) ? '0 : rc + 1'b1;
            snap    <= (tick || sel_chg) ? cur : snap;
            hb      <= tick ? ~hb : hb;
            sat_led <= sat_sel;
            for (int k = 0; k < 6; k++) hex[k] <= selq_ok ? SEG[snap[4*k +: 4]] : 7'b0111111;
        end

`ifdef STATUS_ACT_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYC + 1);
    logic [SW-1:0] st [NUM_CH];

    always_ff @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
        else for (int i = 0; i < NUM_CH; i++)
            st[i] <= bus.ev[i] ? SW'(STRETCH_CYC) : (st[i] != '0 ? st[i] - 1'b1 : st[i]);

    always_comb
        for (int i = 0; i < NUM_CH; i++) act[i] = st[i] != '0;
`else
    always_ff @(posedge clk or posedge reset)
        if (reset) act <= '0;
        else act <= bus.ev;
`endif

    assign bus.hex0 = hex[0];
    assign bus.hex1 = hex[1];
    assign bus.hex2 = hex[2];
    assign bus.hex3 = hex[3];
    assign bus.hex4 = hex[4];
    assign bus.hex5 = hex[5];
    assign bus.ledr = {hb, sat_led, 8'(act)};
endmodule

// File: doc/status_display.md
STATUS_DISPLAY -- requirements
Module: status_display

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of counted event channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 24, meaning per-channel counter width (legal 4..24).
REQ-003 SHALL have parameter REFRESH_CYC, default 5000000, meaning display snapshot period in clk cycles (legal >= 2).
REQ-004 SHALL have parameter STRETCH_CYC, default 2500000, meaning activity LED hold time in clk cycles (legal >= 1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port ev  input  NUM_CH  per-channel event strobe, one count per high cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of all counters and saturation flags.
REQ-009 SHALL have port sel  input  3  channel shown on the 7-segment displays.
REQ-010 SHALL have ports hex0..hex5  output  7 each  active-low segments (bit0 = a ... bit6 = g), hex0 = least significant digit.
REQ-011 SHALL have port ledr  output  10  activity, saturation and heartbeat indicators.

Function
REQ-012 SHALL increment cnt[i] by 1 each cycle ev[i]=1, saturating at 2^CNT_W-1 and setting sticky sat[i] on the saturating attempt.
REQ-013 SHALL, when clr=1, set all cnt and sat to 0 next cycle; clr wins over a simultaneous ev.
REQ-014 SHALL run a refresh counter 0..REFRESH_CYC-1 that wraps, and assert an internal tick in the wrap cycle.
REQ-015 SHALL load snapshot with cnt[sel] (zero-extended to 24 bits) on tick, or in the cycle after sel changes; sel change restarts the refresh counter at 0.
REQ-016 SHALL drive hexK registered from snapshot[4K+3:4K] using the standard hex table (0=1000000, 1=1111001, A=0001000, F=0001110), updated one cycle after snapshot loads.
REQ-017 SHALL, when sel >= NUM_CH, drive every hexK to 0111111 (dash) instead of digits.
REQ-018 SHALL drive ledr[8] = sat[sel] (0 if sel >= NUM_CH), registered.
REQ-019 SHALL toggle ledr[9] on every tick (heartbeat).
REQ-020 SHALL drive ledr[NUM_CH-1:0] per REQ-027/028 and tie every other ledr bit below 8 to 0.
REQ-021 SHALL give clr no effect on snapshot; hex shows 0 only after the next load.
REQ-022 SHALL give a count visible on hex within REFRESH_CYC+2 cycles of the counting ev edge.

Reset
REQ-023 SHALL, while reset=1, set cnt, sat, snapshot, refresh counter and stretch counters to 0 asynchronously.
REQ-024 SHALL hold hex0..hex5 = 1000000 and ledr = 0 during reset.
REQ-025 SHALL count no ev asserted during reset; counting starts on the first edge after release.
REQ-026 SHALL abort any snapshot or stretch in progress when reset is asserted mid-operation, with no residual state.

Configuration
REQ-027 SHALL, with STATUS_ACT_STRETCH_EN defined, load a per-channel down-counter with STRETCH_CYC on ev[i], re-triggerable, and drive ledr[i] = (counter != 0).
REQ-028 SHALL, without STATUS_ACT_STRETCH_EN, drive ledr[i] = ev[i] delayed one cycle and synthesise no stretch counters.

Verification
REQ-029 SHALL cover: NUM_CH=4, REFRESH_CYC=8, three single-cycle ev[2] pulses, sel=2 -> after next tick hex0=0110000 ("3"), hex1..hex5=1000000.
REQ-030 SHALL cover: CNT_W=4, ev[0] held 20 cycles -> cnt[0]=0xF, ledr[8]=1 with sel=0, hex0=0001110.
REQ-031 SHALL cover: clr and ev[1] high in the same cycle with cnt[1]=5 -> cnt[1]=0, sat[1]=0 next cycle.
REQ-032 SHALL cover: sel=5 with NUM_CH=4 -> all hex = 0111111 two cycles later; sel=1 -> digits of cnt[1] two cycles later.
REQ-033 SHALL cover: STATUS_ACT_STRETCH_EN, STRETCH_CYC=10, ev[3] pulse -> ledr[3] high exactly 10 cycles; without macro -> high 1 cycle, delayed 1.
REQ-034 SHALL cover: reset asserted mid-count with cnt[0]=7 -> hex all 1000000, ledr=0 immediately; cnt[0]=0 after release.
